// File: rtl/cpu_decode_stage_pkg.sv
// Shared types and constants for the decode stage: fetch/decode state
// encodings, instruction class encoding and RV32I major opcodes.
package cpu_decode_stage_pkg;

   // Entry state handed over by the fetch stage.
   typedef enum logic [1:0] {
      FETCH_EMPTY = 2'd0,
      FETCH_VALID = 2'd1,
      FETCH_TRAP  = 2'd2
   } fetch_output_state_t;

   // Entry state presented to the execute stage.
   typedef enum logic [1:0] {
      DEC_EMPTY      = 2'd0,
      DEC_VALID      = 2'd1,
      DEC_FETCH_TRAP = 2'd2,
      DEC_ILLEGAL    = 2'd3
   } decode_output_state_t;

   // Instruction class; lui is 0 so a cleared register reads as a harmless class.
   typedef enum logic [3:0] {
      CLASS_LUI      = 4'd0,
      CLASS_AUIPC    = 4'd1,
      CLASS_JAL      = 4'd2,
      CLASS_JALR     = 4'd3,
      CLASS_BRANCH   = 4'd4,
      CLASS_LOAD     = 4'd5,
      CLASS_STORE    = 4'd6,
      CLASS_OP_IMM   = 4'd7,
      CLASS_OP       = 4'd8,
      CLASS_MISC_MEM = 4'd9,
      CLASS_SYSTEM   = 4'd10
   } decode_class_t;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // The only funct3=0 system words we accept: ecall, ebreak, mret.
   localparam logic [31:0] WORD_ECALL  = 32'h00000073;
   localparam logic [31:0] WORD_EBREAK = 32'h00100073;
   localparam logic [31:0] WORD_MRET   = 32'h30200073;

endpackage

// File: rtl/cpu_decode_stage_if.sv
// Fetch-to-decode inputs, pipeline control and the decoded entry handed to
// execute. The decode stage is the slave; the upstream/downstream side is the master.
interface cpu_decode_stage_if;
   import cpu_decode_stage_pkg::*;

   logic [31:0]          fetch_pc;
   logic [31:0]          fetch_instruction;
   fetch_output_state_t  fetch_state;
   logic                 stall;
   logic                 flush;
   logic                 fetch_hold;

   decode_output_state_t output_state;
   logic [31:0]          output_pc;
   logic [31:0]          output_instruction;
   decode_class_t        output_class;
   logic [4:0]           output_rs1;
   logic [4:0]           output_rs2;
   logic [4:0]           output_rd;
   logic [2:0]           output_funct3;
   logic                 output_alt;
   logic [31:0]          output_immediate;
   logic                 output_rd_write;

   modport master (
      output fetch_pc, fetch_instruction, fetch_state, stall, flush,
      input  fetch_hold, output_state, output_pc, output_instruction, output_class,
             output_rs1, output_rs2, output_rd, output_funct3, output_alt,
             output_immediate, output_rd_write
   );

   modport slave (
      input  fetch_pc, fetch_instruction, fetch_state, stall, flush,
      output fetch_hold, output_state, output_pc, output_instruction, output_class,
             output_rs1, output_rs2, output_rd, output_funct3, output_alt,
             output_immediate, output_rd_write
   );
endinterface

// File: rtl/cpu_decode_stage_decoder.sv
// Purely combinational RV32I decoder: class, register fields, sign-extended
// immediate, illegal-instruction flag and register write-back enable.
module cpu_decoder
   import cpu_decode_stage_pkg::*;
(
   input  logic [31:0]   instruction,
   output decode_class_t dec_class,
   output logic [4:0]    rs1,
   output logic [4:0]    rs2,
   output logic [4:0]    rd,
   output logic [2:0]    funct3,
   output logic          alt,
   output logic [31:0]   immediate,
   output logic          illegal,
   output logic          rd_write
);
   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        writes_rd;

   assign opcode = instruction[6:0];
   assign funct7 = instruction[31:25];
   assign rd     = instruction[11:7];
   assign funct3 = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign alt    = instruction[30];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u = {instruction[31:12], 12'b0};
   assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

   // Opcode dispatch: pick class and immediate format, flag reserved encodings.
   always_comb begin
      dec_class = CLASS_LUI;
      immediate = 32'd0;
      illegal   = (instruction[1:0] != 2'b11);
      writes_rd = 1'b0;
      case (opcode)
         OPC_LUI:    begin dec_class = CLASS_LUI;   immediate = imm_u; writes_rd = 1'b1; end
         OPC_AUIPC:  begin dec_class = CLASS_AUIPC; immediate = imm_u; writes_rd = 1'b1; end
         OPC_JAL:    begin dec_class = CLASS_JAL;   immediate = imm_j; writes_rd = 1'b1; end
         OPC_JALR: begin
            dec_class = CLASS_JALR;
            immediate = imm_i;
            writes_rd = 1'b1;
            if (funct3 != 3'd0) illegal = 1'b1;
         end
         OPC_BRANCH: begin
            dec_class = CLASS_BRANCH;
            immediate = imm_b;
            if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
         end
         OPC_LOAD: begin
            dec_class = CLASS_LOAD;
            immediate = imm_i;
            writes_rd = 1'b1;
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
         end
         OPC_STORE: begin
            dec_class = CLASS_STORE;
            immediate = imm_s;
            if (funct3 > 3'd2) illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_class = CLASS_OP_IMM;
            immediate = imm_i;
            writes_rd = 1'b1;
            // Shift-immediates reuse the upper immediate bits as funct7.
            if (funct3 == 3'd1 && funct7 != 7'h00) illegal = 1'b1;
            if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
         end
         OPC_OP: begin
            dec_class = CLASS_OP;
            writes_rd = 1'b1;
            if (funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
            if (funct7 == 7'h20 && funct3 != 3'd0 && funct3 != 3'd5) illegal = 1'b1;
         end
         OPC_MISC_MEM: begin
            dec_class = CLASS_MISC_MEM;
            if (funct3 > 3'd1) illegal = 1'b1;
         end
         OPC_SYSTEM: begin
            dec_class = CLASS_SYSTEM;
            immediate = imm_i;
            if (funct3 == 3'd4) begin
               illegal = 1'b1;
            end else if (funct3 == 3'd0) begin
               if (instruction != WORD_ECALL && instruction != WORD_EBREAK &&
                   instruction != WORD_MRET)
                  illegal = 1'b1;
            end else begin
               writes_rd = 1'b1;   // CSR access
            end
         end
         default: illegal = 1'b1;
      endcase
   end

   assign rd_write = writes_rd && (rd != 5'd0) && !illegal;
endmodule

// File: rtl/cpu_decode_stage.sv
// Decode pipeline stage: decodes the fetched word and holds the result in a
// one-entry register toward execute, with stall (hold) and flush (invalidate).
module cpu_decode_stage
   import cpu_decode_stage_pkg::*;
#(
   parameter logic [31:0] reset_vector = 32'hXXXXXXXX
) (
   input  logic               clk,
   input  logic               reset,
   cpu_decode_stage_if.slave  bus
);
   decode_class_t dec_class;
   logic [4:0]    dec_rs1, dec_rs2, dec_rd;
   logic [2:0]    dec_funct3;
   logic          dec_alt;
   logic [31:0]   dec_immediate;
   logic          dec_illegal;
   logic          dec_rd_write;

   cpu_decoder u_decoder (
      .instruction (bus.fetch_instruction),
      .dec_class   (dec_class),
      .rs1         (dec_rs1),
      .rs2         (dec_rs2),
      .rd          (dec_rd),
      .funct3      (dec_funct3),
      .alt         (dec_alt),
      .immediate   (dec_immediate),
      .illegal     (dec_illegal),
      .rd_write    (dec_rd_write)
   );

   // A flush overrides a stall, so fetch is only told to wait when no flush is pending.
   assign bus.fetch_hold = bus.stall & ~bus.flush;

   // Pipeline register: reset > flush > stall > load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.output_state       <= DEC_EMPTY;
         bus.output_pc          <= reset_vector;
         bus.output_instruction <= 32'd0;
         bus.output_class       <= CLASS_LUI;
         bus.output_rs1         <= 5'd0;
         bus.output_rs2         <= 5'd0;
         bus.output_rd          <= 5'd0;
         bus.output_funct3      <= 3'd0;
         bus.output_alt         <= 1'b0;
         bus.output_immediate   <= 32'd0;
         bus.output_rd_write    <= 1'b0;
      end else if (bus.flush) begin
         bus.output_state <= DEC_EMPTY;
      end else if (!bus.stall) begin
         bus.output_pc <= bus.fetch_pc;
         if (bus.fetch_state == FETCH_TRAP) begin
            // Fetch fault: only the pc is meaningful to the trap handler.
            bus.output_state       <= DEC_FETCH_TRAP;
            bus.output_instruction <= 32'd0;
            bus.output_class       <= CLASS_LUI;
            bus.output_rs1         <= 5'd0;
            bus.output_rs2         <= 5'd0;
            bus.output_rd          <= 5'd0;
            bus.output_funct3      <= 3'd0;
            bus.output_alt         <= 1'b0;
            bus.output_immediate   <= 32'd0;
            bus.output_rd_write    <= 1'b0;
         end else begin
            if (bus.fetch_state == FETCH_VALID)
               bus.output_state <= dec_illegal ? DEC_ILLEGAL : DEC_VALID;
            else
               bus.output_state <= DEC_EMPTY;
            bus.output_instruction <= bus.fetch_instruction;
            bus.output_class       <= dec_class;
            bus.output_rs1         <= dec_rs1;
            bus.output_rs2         <= dec_rs2;
            bus.output_rd          <= dec_rd;
            bus.output_funct3      <= dec_funct3;
            bus.output_alt         <= dec_alt;
            bus.output_immediate   <= dec_immediate;
            // Bubbles never write back, even if the stale word would.
            bus.output_rd_write    <= dec_rd_write && (bus.fetch_state == FETCH_VALID);
         end
      end
   end
endmodule

// File: tb/tb_cpu_decode_stage.sv
// Directed bench for cpu_decode_stage: hand-decoded RV32I words, fetch trap,
// stall/flush interplay and asynchronous reset in the middle of a stall.
module tb_cpu_decode_stage;
   import cpu_decode_stage_pkg::*;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0080;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   cpu_decode_stage_if bus ();

   cpu_decode_stage #(.reset_vector(RESET_VECTOR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                        input fetch_output_state_t st);
      bus.fetch_pc          = pc;
      bus.fetch_instruction = instr;
      bus.fetch_state       = st;
   endtask

   // Load one valid word and check state, class, rd, immediate and rd_write.
   task automatic decode_txn(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input decode_output_state_t exp_state, input decode_class_t exp_class,
                             input logic [4:0] exp_rd, input logic [31:0] exp_imm,
                             input logic exp_wr);
      drive(pc, instr, FETCH_VALID);
      tick();
      $display("txn %s pc=%08h instr=%08h state=%0d class=%0d imm=%08h wr=%0b",
               tag, pc, instr, bus.output_state, bus.output_class,
               bus.output_immediate, bus.output_rd_write);
      check_val({tag, ".state"}, 32'(bus.output_state), 32'(exp_state));
      check_val({tag, ".pc"},    bus.output_pc, pc);
      check_val({tag, ".instr"}, bus.output_instruction, instr);
      check_val({tag, ".wr"},    32'(bus.output_rd_write), 32'(exp_wr));
      if (exp_state == DEC_VALID) begin
         check_val({tag, ".class"}, 32'(bus.output_class), 32'(exp_class));
         check_val({tag, ".rd"},    32'(bus.output_rd), 32'(exp_rd));
         check_val({tag, ".imm"},   bus.output_immediate, exp_imm);
      end
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [31:0] held_instr;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(32'h0, 32'h0, FETCH_EMPTY);
      #1;
      check_val("reset.state", 32'(bus.output_state), 32'(DEC_EMPTY));
      check_val("reset.pc",    bus.output_pc, RESET_VECTOR);
      check_val("reset.imm",   bus.output_immediate, 32'd0);
      check_val("reset.wr",    32'(bus.output_rd_write), 32'd0);
      check_val("reset.hold",  32'(bus.fetch_hold), 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // Legal decodes.
      decode_txn("addi", 32'h100, 32'hFFF00093, DEC_VALID, CLASS_OP_IMM, 5'd1, 32'hFFFFFFFF, 1'b1);
      decode_txn("beq",  32'h104, 32'hFE000EE3, DEC_VALID, CLASS_BRANCH, 5'd29, 32'hFFFFFFFC, 1'b0);
      decode_txn("sw",   32'h108, 32'h00112623, DEC_VALID, CLASS_STORE,  5'd12, 32'h0000000C, 1'b0);
      decode_txn("lui",  32'h10C, 32'h123450B7, DEC_VALID, CLASS_LUI,    5'd1, 32'h12345000, 1'b1);
      decode_txn("jal",  32'h110, 32'h0080006F, DEC_VALID, CLASS_JAL,    5'd0, 32'h00000008, 1'b0);
      decode_txn("sub",  32'h114, 32'h40208133, DEC_VALID, CLASS_OP,     5'd2, 32'h00000000, 1'b1);
      check_val("sub.alt", 32'(bus.output_alt), 32'd1);
      decode_txn("ecall", 32'h118, 32'h00000073, DEC_VALID, CLASS_SYSTEM, 5'd0, 32'h00000000, 1'b0);

      // Illegal encodings.
      decode_txn("zero", 32'h11C, 32'h00000000, DEC_ILLEGAL, CLASS_LUI, 5'd0, 32'd0, 1'b0);
      decode_txn("ld3",  32'h120, 32'h0000B003, DEC_ILLEGAL, CLASS_LUI, 5'd0, 32'd0, 1'b0);
      decode_txn("sllx", 32'h124, 32'h40001033, DEC_ILLEGAL, CLASS_LUI, 5'd0, 32'd0, 1'b0);

      // Fetch trap.
      drive(32'h200, 32'hFFF00093, FETCH_TRAP);
      tick();
      $display("txn trap pc=%08h state=%0d", bus.output_pc, bus.output_state);
      check_val("trap.state", 32'(bus.output_state), 32'(DEC_FETCH_TRAP));
      check_val("trap.pc",    bus.output_pc, 32'h200);
      check_val("trap.instr", bus.output_instruction, 32'd0);
      check_val("trap.wr",    32'(bus.output_rd_write), 32'd0);

      // Bubble.
      drive(32'h204, 32'hFFF00093, FETCH_EMPTY);
      tick();
      $display("txn bubble state=%0d", bus.output_state);
      check_val("bubble.state", 32'(bus.output_state), 32'(DEC_EMPTY));
      check_val("bubble.wr",    32'(bus.output_rd_write), 32'd0);

      // Stall for three cycles while inputs change.
      decode_txn("pre_stall", 32'h300, 32'hFFF00093, DEC_VALID, CLASS_OP_IMM, 5'd1, 32'hFFFFFFFF, 1'b1);
      held_pc    = 32'h300;
      held_instr = 32'hFFF00093;
      bus.stall  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(32'h400 + 32'(k * 4), 32'h123450B7, FETCH_VALID);
         #1;
         check_val("stall.hold", 32'(bus.fetch_hold), 32'd1);
         tick();
         $display("txn stall%0d pc=%08h state=%0d", k, bus.output_pc, bus.output_state);
         check_val("stall.pc",    bus.output_pc, held_pc);
         check_val("stall.instr", bus.output_instruction, held_instr);
         check_val("stall.state", 32'(bus.output_state), 32'(DEC_VALID));
      end

      // Stall and flush together: flush wins.
      bus.flush = 1'b1;
      #1;
      check_val("flush.hold", 32'(bus.fetch_hold), 32'd0);
      tick();
      $display("txn flush state=%0d", bus.output_state);
      check_val("flush.state", 32'(bus.output_state), 32'(DEC_EMPTY));
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // Asynchronous reset in the middle of a stall.
      decode_txn("pre_rst", 32'h500, 32'h123450B7, DEC_VALID, CLASS_LUI, 5'd1, 32'h12345000, 1'b1);
      bus.stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      $display("txn async_reset state=%0d pc=%08h", bus.output_state, bus.output_pc);
      check_val("arst.state", 32'(bus.output_state), 32'(DEC_EMPTY));
      check_val("arst.pc",    bus.output_pc, RESET_VECTOR);
      check_val("arst.imm",   bus.output_immediate, 32'd0);
      check_val("arst.hold",  32'(bus.fetch_hold), 32'd1);
      tick();
      reset     = 1'b0;
      bus.stall = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
